// File: rtl/puks_pkg.sv
// Shared types for the PUKS power sequencer: state encoding, registered output
// levels per state, and the sizing rule for the shared down-counter.
package puks_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PON     = 3'd1,
    ST_RUN     = 3'd2,
    ST_CLR_ALL = 3'd3,
    ST_CLR_MOD = 3'd4,
    ST_POUT    = 3'd5
  } state_e;

  typedef struct packed {
    logic off_n;
    logic pon_n;
    logic pout_n;
    logic clo_n;
    logic clm_n;
    logic busy;
  } outs_t;

  localparam outs_t OUT_OFF = '{off_n: 1'b0, pon_n: 1'b1, pout_n: 1'b1,
                                clo_n: 1'b0, clm_n: 1'b0, busy: 1'b1};
  localparam outs_t OUT_PON = '{off_n: 1'b1, pon_n: 1'b0, pout_n: 1'b1,
                                clo_n: 1'b0, clm_n: 1'b0, busy: 1'b1};
  localparam outs_t OUT_RUN = '{off_n: 1'b1, pon_n: 1'b1, pout_n: 1'b1,
                                clo_n: 1'b1, clm_n: 1'b1, busy: 1'b0};
  localparam outs_t OUT_CLR_ALL = '{off_n: 1'b1, pon_n: 1'b1, pout_n: 1'b1,
                                    clo_n: 1'b0, clm_n: 1'b0, busy: 1'b1};
  localparam outs_t OUT_CLR_MOD = '{off_n: 1'b1, pon_n: 1'b1, pout_n: 1'b1,
                                    clo_n: 1'b1, clm_n: 1'b0, busy: 1'b1};
  localparam outs_t OUT_POUT = '{off_n: 1'b1, pon_n: 1'b1, pout_n: 1'b0,
                                 clo_n: 1'b0, clm_n: 1'b0, busy: 1'b1};

  function automatic outs_t state_outs(input state_e s);
    outs_t o;
    case (s)
      ST_OFF:     o = OUT_OFF;
      ST_PON:     o = OUT_PON;
      ST_RUN:     o = OUT_RUN;
      ST_CLR_ALL: o = OUT_CLR_ALL;
      ST_CLR_MOD: o = OUT_CLR_MOD;
      ST_POUT:    o = OUT_POUT;
      default:    o = OUT_OFF;
    endcase
    return o;
  endfunction

  // Wide enough to hold the largest tick count without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable saturating down-counter shared by every sequencer state.
// done_o flags that the current cycle completes (or has passed) the loaded interval.
module seq_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 1 means this edge is the N-th of an N-cycle interval.
  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/puks_seq.sv
// PUKS power sequencer: qualifies supply status, emits -PON/-POUT strobes and
// arbitrates clear requests into stretched -CLO/-CLM, all outputs registered.
module puks_seq
  import puks_pkg::*;
#(
  parameter int STABLE_TICKS = 16,
  parameter int PULSE_TICKS  = 8,
  parameter int CLR_TICKS    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pwr_ok,
  input  logic zoff_,
  input  logic dcl_,
  input  logic rcl_,
  output logic off_,
  output logic pon_,
  output logic pout_,
  output logic clo_,
  output logic clm_,
  output logic busy
);

  localparam int CW = cnt_width(STABLE_TICKS, PULSE_TICKS, CLR_TICKS);
  localparam logic [CW-1:0] STABLE_LD = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_TICKS);
  localparam logic [CW-1:0] CLR_LD    = CW'(CLR_TICKS);

  state_e        state_q, state_d;
  outs_t         outs_q;
  logic          tmr_load, tmr_en, tmr_done;
  logic [CW-1:0] tmr_val;
  logic          pwr_up;

  assign pwr_up = pwr_ok & zoff_;

  seq_timer #(
    .W      (CW),
    .RST_VAL(STABLE_LD)
  ) u_timer (
    .clk       (clk),
    .rst       (reset),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_en   = (state_q != ST_RUN);
    tmr_val  = STABLE_LD;

    case (state_q)
      ST_OFF: begin
        if (!pwr_up) begin
          tmr_load = 1'b1;
          tmr_val  = STABLE_LD;
        end else if (tmr_done) begin
          state_d  = ST_PON;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end

      ST_PON: begin
        if (!pwr_up) begin
          state_d  = ST_POUT;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end else if (tmr_done) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!pwr_up) begin
          state_d  = ST_POUT;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end else if (!dcl_) begin
          state_d  = ST_CLR_ALL;
          tmr_load = 1'b1;
          tmr_val  = CLR_LD;
        end else if (!rcl_) begin
          state_d  = ST_CLR_MOD;
          tmr_load = 1'b1;
          tmr_val  = CLR_LD;
        end
      end

      ST_CLR_ALL: begin
        if (!pwr_up) begin
          state_d  = ST_POUT;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end else if (tmr_done && dcl_) begin
          // A pending module reset takes over directly instead of passing through RUN.
          if (!rcl_) begin
            state_d  = ST_CLR_MOD;
            tmr_load = 1'b1;
            tmr_val  = CLR_LD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_CLR_MOD: begin
        if (!pwr_up) begin
          state_d  = ST_POUT;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end else if (!dcl_) begin
          state_d  = ST_CLR_ALL;
          tmr_load = 1'b1;
          tmr_val  = CLR_LD;
        end else if (tmr_done && rcl_) begin
          state_d = ST_RUN;
        end
      end

      ST_POUT: begin
        // Runs to completion regardless of the supply coming back.
        if (tmr_done) begin
          state_d  = ST_OFF;
          tmr_load = 1'b1;
          tmr_val  = STABLE_LD;
        end
      end

      default: begin
        state_d  = ST_OFF;
        tmr_load = 1'b1;
        tmr_val  = STABLE_LD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      outs_q  <= OUT_OFF;
    end else begin
      state_q <= state_d;
      outs_q  <= state_outs(state_d);
    end
  end

  assign off_  = outs_q.off_n;
  assign pon_  = outs_q.pon_n;
  assign pout_ = outs_q.pout_n;
  assign clo_  = outs_q.clo_n;
  assign clm_  = outs_q.clm_n;
  assign busy  = outs_q.busy;

endmodule
